// File: rtl/oam_dma.sv
// OAM DMA bus master: snoops CPU writes to the DMA register and copies LENGTH
// bytes from the selected source page to OAM through the mmu port.
module oam_dma #(
  parameter int unsigned LENGTH    = 160,
  parameter logic [15:0] DEST_BASE = 16'hFE00,
  parameter logic [15:0] REG_ADDR  = 16'hFF46
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic        iCpuWe,
  input  logic [7:0]  iCpuData,
  input  logic [7:0]  iData,
  output logic        oBusReq,
  output logic [15:0] oAddr,
  output logic        oWe,
  output logic [7:0]  oData,
  output logic        oBusy,
  output logic        oDone,
  output logic [7:0]  oRegData
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] READ  = 3'd2;
  localparam logic [2:0] LATCH = 3'd3;
  localparam logic [2:0] WRITE = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 32'd1);

  // Source pages E0-FF alias the work RAM at C0-DF.
  function automatic logic [7:0] foldEcho(input logic [7:0] page);
    if (page >= 8'hE0) begin
      foldEcho = page - 8'h20;
    end else begin
      foldEcho = page;
    end
  endfunction

  logic [2:0]  stateR,   stateS;
  logic [7:0]  counterR, counterS;
  logic [7:0]  srcHiR,   srcHiS;
  logic [7:0]  latchR,   latchS;
  logic [7:0]  regR,     regS;

  logic        busReqR,  busReqS;
  logic [15:0] addrR,    addrS;
  logic        weR,      weS;
  logic [7:0]  dataR,    dataS;
  logic        busyR,    busyS;
  logic        doneR,    doneS;

  logic        triggerS;

  assign triggerS = iCpuWe && (iCpuAddr == REG_ADDR);

  // Next-state sequencing; a register write overrides whatever the FSM was doing.
  always_comb begin
    stateS   = stateR;
    counterS = counterR;
    srcHiS   = srcHiR;
    latchS   = latchR;
    regS     = regR;
    case (stateR)
      IDLE:  stateS = IDLE;
      START: stateS = READ;
      READ:  stateS = LATCH;
      LATCH: begin
        stateS = WRITE;
        latchS = iData;
      end
      WRITE: begin
        if (counterR == LAST_IDX) begin
          stateS = DONE;
        end else begin
          counterS = counterR + 8'd1;
          stateS   = READ;
        end
      end
      DONE:    stateS = IDLE;
      default: stateS = IDLE;
    endcase
    if (triggerS) begin
      regS     = iCpuData;
      srcHiS   = foldEcho(iCpuData);
      counterS = 8'd0;
      stateS   = START;
    end else begin
      regS = regS;
    end
  end

  // Bus outputs are decoded from the upcoming state so they leave a register.
  always_comb begin
    busReqS = 1'b0;
    addrS   = 16'h0000;
    weS     = 1'b0;
    dataS   = 8'h00;
    busyS   = 1'b0;
    doneS   = 1'b0;
    case (stateS)
      IDLE: busyS = 1'b0;
      START: busyS = 1'b1;
      READ, LATCH: begin
        busReqS = 1'b1;
        busyS   = 1'b1;
        addrS   = {srcHiS, counterS};
      end
      WRITE: begin
        busReqS = 1'b1;
        busyS   = 1'b1;
        weS     = 1'b1;
        addrS   = DEST_BASE + {8'h00, counterS};
        dataS   = latchS;
      end
      DONE:    doneS = 1'b1;
      default: doneS = 1'b0;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      stateR   <= IDLE;
      counterR <= 8'd0;
      srcHiR   <= 8'h00;
      latchR   <= 8'h00;
      regR     <= 8'h00;
      busReqR  <= 1'b0;
      addrR    <= 16'h0000;
      weR      <= 1'b0;
      dataR    <= 8'h00;
      busyR    <= 1'b0;
      doneR    <= 1'b0;
    end else begin
      stateR   <= stateS;
      counterR <= counterS;
      srcHiR   <= srcHiS;
      latchR   <= latchS;
      regR     <= regS;
      busReqR  <= busReqS;
      addrR    <= addrS;
      weR      <= weS;
      dataR    <= dataS;
      busyR    <= busyS;
      doneR    <= doneS;
    end
  end

  assign oBusReq  = busReqR;
  assign oAddr    = addrR;
  assign oWe      = weR;
  assign oData    = dataR;
  assign oBusy    = busyR;
  assign oDone    = doneR;
  assign oRegData = regR;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma with a synchronous-read mmu model.
module tb_oam_dma;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [15:0] iCpuAddr;
  logic        iCpuWe;
  logic [7:0]  iCpuData;
  logic [7:0]  iData = 8'h00;
  logic        oBusReq;
  logic [15:0] oAddr;
  logic        oWe;
  logic [7:0]  oData;
  logic        oBusy;
  logic        oDone;
  logic [7:0]  oRegData;

  oam_dma dut (
    .iClock(iClock), .iReset(iReset), .iCpuAddr(iCpuAddr), .iCpuWe(iCpuWe),
    .iCpuData(iCpuData), .iData(iData), .oBusReq(oBusReq), .oAddr(oAddr),
    .oWe(oWe), .oData(oData), .oBusy(oBusy), .oDone(oDone), .oRegData(oRegData)
  );

  always #5 iClock = ~iClock;

  logic [7:0] mem [0:65535];

  // mmu model: registered read data, write on strobe.
  always @(posedge iClock) begin
    if (oBusReq && oWe) mem[oAddr] <= oData;
    iData <= mem[oAddr];
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] addrAt   [0:1023];
  logic        weAt     [0:1023];
  logic [7:0]  dataAt   [0:1023];
  logic        busReqAt [0:1023];
  logic        busyAt   [0:1023];
  logic        doneAt   [0:1023];
  int writeCnt, busyCnt, doneCnt, doneRel, idleViol, busReqCnt;

  task automatic trigger(input logic [7:0] v);
    @(negedge iClock);
    iCpuAddr = 16'hFF46;
    iCpuWe   = 1'b1;
    iCpuData = v;
  endtask

  // Observe n cycles after a trigger; optional CPU writes issued during cycles r1/r2.
  task automatic observe(input int n, input int r1, input logic [15:0] a1, input logic [7:0] d1,
                         input int r2, input logic [15:0] a2, input logic [7:0] d2);
    writeCnt = 0; busyCnt = 0; doneCnt = 0; doneRel = -1; idleViol = 0; busReqCnt = 0;
    for (int rel = 1; rel <= n; rel++) begin
      @(negedge iClock);
      addrAt[rel] = oAddr; weAt[rel] = oWe; dataAt[rel] = oData;
      busReqAt[rel] = oBusReq; busyAt[rel] = oBusy; doneAt[rel] = oDone;
      if (oWe) writeCnt++;
      if (oBusy) busyCnt++;
      if (oBusReq) busReqCnt++;
      if (oDone) begin
        doneCnt++;
        if (doneRel < 0) doneRel = rel;
      end
      if (!oBusReq && (oAddr != 16'h0000 || oWe || oData != 8'h00)) idleViol++;
      iCpuWe = 1'b0; iCpuAddr = 16'h0000; iCpuData = 8'h00;
      if (rel == r1) begin iCpuWe = 1'b1; iCpuAddr = a1; iCpuData = d1; end
      if (rel == r2) begin iCpuWe = 1'b1; iCpuAddr = a2; iCpuData = d2; end
    end
    iCpuWe = 1'b0; iCpuAddr = 16'h0000; iCpuData = 8'h00;
  endtask

  int bad;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 160; i++) begin
      mem[16'hC000 + i] = 8'(i) ^ 8'h5A;
      mem[16'hC100 + i] = 8'(i) ^ 8'h3C;
      mem[16'hD000 + i] = 8'(i) ^ 8'hA5;
    end
    mem[16'h8000] = 8'h77;
    iReset = 1'b0; iCpuAddr = 16'h0000; iCpuWe = 1'b0; iCpuData = 8'h00;
    repeat (3) @(posedge iClock);
    #1;
    check("rst_busreq", oBusReq, 1'b0);
    check("rst_addr", oAddr, 16'h0000);
    check("rst_busy_done", {oBusy, oDone, oWe}, 3'b000);
    check("rst_regdata", oRegData, 8'h00);
    @(negedge iClock); iReset = 1'b1;

    // Asynchronous reset in the middle of a READ
    trigger(8'hC0);
    observe(2, 0, 16'h0, 8'h0, 0, 16'h0, 8'h0);
    check("pre_rst_read", {busReqAt[2], addrAt[2]}, {1'b1, 16'hC000});
    #2 iReset = 1'b0;
    #1;
    check("async_rst_bus", {oBusReq, oWe, oBusy, oDone}, 4'b0000);
    check("async_rst_addr", oAddr, 16'h0000);
    check("async_rst_reg", oRegData, 8'h00);
    @(negedge iClock); iReset = 1'b1;
    observe(20, 0, 16'h0, 8'h0, 0, 16'h0, 8'h0);
    check("idle_no_busreq", busReqCnt, 0);

    // Basic transfer from C000
    trigger(8'hC0);
    observe(485, 0, 16'h0, 8'h0, 0, 16'h0, 8'h0);
    check("basic_start", {busReqAt[1], busyAt[1]}, 2'b01);
    check("basic_read0", {busReqAt[2], weAt[2], addrAt[2]}, {2'b10, 16'hC000});
    check("basic_write0", {weAt[4], addrAt[4], dataAt[4]}, {1'b1, 16'hFE00, 8'h5A});
    check("basic_write_last", {weAt[481], addrAt[481], dataAt[481]}, {1'b1, 16'hFE9F, 8'hC5});
    check("basic_done", {doneAt[482], busyAt[482]}, 2'b10);
    check("basic_done_rel", doneRel, 482);
    check("basic_done_cnt", doneCnt, 1);
    check("basic_writes", writeCnt, 160);
    check("basic_busy", busyCnt, 481);
    check("basic_idle_bus", idleViol, 0);
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== (8'(i) ^ 8'h5A)) bad++;
    check("basic_oam_image", bad, 0);

    // Echo RAM fold
    trigger(8'hE1);
    observe(485, 0, 16'h0, 8'h0, 0, 16'h0, 8'h0);
    check("echo_read0", addrAt[2], 16'hC100);
    check("echo_read_last", addrAt[479], 16'hC19F);
    check("echo_write0", dataAt[4], 8'h3C);
    check("echo_regdata", oRegData, 8'hE1);
    check("echo_done_rel", doneRel, 482);

    // Restart at byte 50's LATCH cycle
    trigger(8'hC0);
    observe(640, 153, 16'hFF46, 8'hD0, 0, 16'h0, 8'h0);
    check("rst50_read", addrAt[152], 16'hC032);
    check("rst50_newread", addrAt[155], 16'hD000);
    check("rst50_write0", {weAt[157], addrAt[157], dataAt[157]}, {1'b1, 16'hFE00, 8'hA5});
    check("rst50_done_cnt", doneCnt, 1);
    check("rst50_done_rel", doneRel, 635);
    check("rst50_writes", writeCnt, 210);
    check("rst50_busy", busyCnt, 634);
    check("rst50_regdata", oRegData, 8'hD0);

    // Writes to neighbouring registers are ignored
    trigger(8'hC0);
    observe(485, 100, 16'hFF45, 8'h11, 200, 16'hFF47, 8'h22);
    check("nomatch_done_rel", doneRel, 482);
    check("nomatch_writes", writeCnt, 160);
    check("nomatch_regdata", oRegData, 8'hC0);
    check("nomatch_busy", busyCnt, 481);

    // Trigger coincident with the final WRITE
    trigger(8'hC0);
    observe(966, 481, 16'hFF46, 8'h80, 0, 16'h0, 8'h0);
    check("simul_last_write", {weAt[481], addrAt[481], dataAt[481]}, {1'b1, 16'hFE9F, 8'hC5});
    check("simul_no_done", {doneAt[482], busyAt[482]}, 2'b01);
    check("simul_read", {busReqAt[483], addrAt[483]}, {1'b1, 16'h8000});
    check("simul_write0", {weAt[485], addrAt[485], dataAt[485]}, {1'b1, 16'hFE00, 8'h77});
    check("simul_done_rel", doneRel, 963);
    check("simul_done_cnt", doneCnt, 1);
    check("simul_busy", busyCnt, 962);
    check("simul_idle_bus", idleViol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
